// File: rtl/io_port_responder.sv
// IO-space responder: control/status/data registers, TX byte FIFO drained as a
// valid/ready stream, and an RX holding register read back through the data port.
module io_port_responder #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] CTRL_ADDR   = 6'h0A,
  parameter logic [ADDR_WIDTH-1:0] STATUS_ADDR = 6'h0B,
  parameter logic [ADDR_WIDTH-1:0] DATA_ADDR   = 6'h0C
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] io_addr,
  input  logic [DATA_WIDTH-1:0] io_wdata,
  input  logic                  io_write,
  input  logic                  io_read,
  output logic [DATA_WIDTH-1:0] io_rdata,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_strobe
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  logic                  rd_q;
  logic                  wr_q;
  logic [6:0]            ctrl;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  rx_full;
  logic [DATA_WIDTH-1:0] rx_hold;
  logic                  tx_ovf;
  logic                  rx_ovr;

  logic wr_edge, rd_edge;
  logic ctrl_wr, status_wr, data_wr, data_rd;
  logic fifo_full, fifo_empty, push_ok, pop, flush;
  logic ovf_set, ovf_clr, ovr_set, ovr_clr, rx_load;
  logic [CNT_W-1:0] cnt_inc, cnt_dec;
  logic [DATA_WIDTH-1:0] status;

  assign wr_edge   = io_write & ~wr_q;
  assign rd_edge   = io_read & ~rd_q;
  assign ctrl_wr   = wr_edge & (io_addr == CTRL_ADDR);
  assign status_wr = wr_edge & (io_addr == STATUS_ADDR);
  assign data_wr   = wr_edge & (io_addr == DATA_ADDR);
  assign data_rd   = rd_edge & (io_addr == DATA_ADDR);

  assign fifo_full  = (count == CNT_FULL);
  assign fifo_empty = (count == {CNT_W{1'b0}});
  assign tx_valid   = ctrl[0] & ~fifo_empty;
  assign tx_data    = mem[rd_ptr];
  assign pop        = tx_valid & tx_ready;
  assign push_ok    = data_wr & ~fifo_full;
  assign flush      = ctrl_wr & io_wdata[7];
  assign cnt_inc    = {{(CNT_W-1){1'b0}}, push_ok};
  assign cnt_dec    = {{(CNT_W-1){1'b0}}, pop};

  // Sticky flags: a set in the same cycle as a W1C clear wins.
  assign ovf_set = data_wr & fifo_full;
  assign ovf_clr = status_wr & io_wdata[3];
  assign rx_load = rx_strobe & ctrl[1];
  assign ovr_set = rx_load & rx_full & ~data_rd;
  assign ovr_clr = status_wr & io_wdata[4];

  assign status = {3'b000, rx_ovr, tx_ovf, rx_full, fifo_empty, fifo_full};

  // Read mux: live view of register state while io_read is held.
  always_comb begin
    io_rdata = {DATA_WIDTH{1'b0}};
    if (io_read) begin
      case (io_addr)
        CTRL_ADDR:   io_rdata = {1'b0, ctrl};
        STATUS_ADDR: io_rdata = status;
        DATA_ADDR:   io_rdata = rx_hold;
        default:     io_rdata = {DATA_WIDTH{1'b0}};
      endcase
    end else begin
      io_rdata = {DATA_WIDTH{1'b0}};
    end
  end

  // All register, FIFO and RX state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      ctrl    <= 7'h00;
      wr_ptr  <= {PTR_W{1'b0}};
      rd_ptr  <= {PTR_W{1'b0}};
      count   <= {CNT_W{1'b0}};
      rx_full <= 1'b0;
      rx_hold <= {DATA_WIDTH{1'b0}};
      tx_ovf  <= 1'b0;
      rx_ovr  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      rd_q <= io_read;
      wr_q <= io_write;

      if (ctrl_wr) begin
        ctrl <= io_wdata[6:0];
      end

      // Flush discards a concurrent pop; otherwise fullness is judged pre-edge.
      if (flush) begin
        wr_ptr <= {PTR_W{1'b0}};
        rd_ptr <= {PTR_W{1'b0}};
        count  <= {CNT_W{1'b0}};
      end else begin
        if (push_ok) begin
          mem[wr_ptr] <= io_wdata;
          wr_ptr      <= wr_ptr + PTR_ONE;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_ONE;
        end
        count <= count + cnt_inc - cnt_dec;
      end

      tx_ovf <= ovf_set | (tx_ovf & ~ovf_clr);
      rx_ovr <= ovr_set | (rx_ovr & ~ovr_clr);

      if (rx_load) begin
        rx_hold <= rx_data;
        rx_full <= 1'b1;
      end else if (data_rd) begin
        rx_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_io_port_responder.sv
// Scoreboard bench for io_port_responder: expected TX bytes are queued on DATA
// writes and compared as the stream hands them out; register reads are checked directly.
module tb_io_port_responder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] io_addr;
  logic [7:0] io_wdata;
  logic       io_write;
  logic       io_read;
  logic [7:0] io_rdata;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_strobe;

  localparam logic [5:0] A_CTRL = 6'h0A;
  localparam logic [5:0] A_STAT = 6'h0B;
  localparam logic [5:0] A_DATA = 6'h0C;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rd_val;

  io_port_responder dut (
    .clk(clk), .rst_n(rst_n), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_write(io_write), .io_read(io_read), .io_rdata(io_rdata),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_strobe(rx_strobe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Stream monitor: every accepted byte must be the oldest expected one.
  always @(negedge clk) begin
    #1;
    if (rst_n && tx_valid && tx_ready) begin
      if (exp_q.size() == 0) begin
        check("tx_unexpected", {24'h0, tx_data}, 32'hFFFF_FFFF);
      end else begin
        check("tx_data", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  // DATA writes feed the scoreboard; writes are only issued while nothing drains.
  task automatic io_wr(input logic [5:0] a, input logic [7:0] d);
    @(negedge clk);
    io_addr = a; io_wdata = d; io_write = 1'b1;
    if (a == A_DATA && exp_q.size() < 4) exp_q.push_back(d);
    if (a == A_CTRL && d[7]) exp_q.delete();
    @(negedge clk);
    io_write = 1'b0;
  endtask

  task automatic io_rd(input logic [5:0] a, output logic [7:0] d);
    @(negedge clk);
    io_addr = a; io_read = 1'b1;
    #1 d = io_rdata;
    @(negedge clk);
    io_read = 1'b0;
  endtask

  task automatic rx_pulse(input logic [7:0] d);
    @(negedge clk);
    rx_data = d; rx_strobe = 1'b1;
    @(negedge clk);
    rx_strobe = 1'b0;
  endtask

  task automatic drain(input string tag);
    @(negedge clk);
    tx_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    tx_ready = 1'b0;
    check(tag, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; io_addr = 6'h00; io_wdata = 8'h00; io_write = 1'b0; io_read = 1'b0;
    tx_ready = 1'b0; rx_data = 8'h00; rx_strobe = 1'b0;
    #12;
    check("rst_valid", tx_valid, 1'b0);
    check("rst_txdata", tx_data, 8'h00);
    check("rst_rdata", io_rdata, 8'h00);
    @(negedge clk); rst_n = 1'b1;
    io_rd(A_STAT, rd_val); check("rst_status", rd_val, 8'h02);
    io_rd(A_CTRL, rd_val); check("rst_ctrl", rd_val, 8'h00);

    // Basic stream: two bytes out on consecutive cycles.
    io_wr(A_CTRL, 8'h01);
    io_wr(A_DATA, 8'hA1);
    check("valid_after_write", tx_valid, 1'b1);
    io_wr(A_DATA, 8'hB2);
    drain("drain_basic");
    check("valid_after_drain", tx_valid, 1'b0);
    io_rd(A_STAT, rd_val); check("status_basic", rd_val, 8'h02);

    // Overfill with tx disabled: fifth byte dropped, overflow sticky, then W1C.
    io_wr(A_CTRL, 8'h00);
    for (int i = 1; i <= 5; i++) io_wr(A_DATA, 8'(i));
    check("valid_disabled", tx_valid, 1'b0);
    io_rd(A_STAT, rd_val); check("status_full", rd_val, 8'h09);
    io_wr(A_CTRL, 8'h01);
    drain("drain_full");
    io_rd(A_STAT, rd_val); check("status_ovf_kept", rd_val, 8'h0A);
    io_wr(A_STAT, 8'h08);
    io_rd(A_STAT, rd_val); check("status_w1c", rd_val, 8'h02);
    io_rd(A_DATA, rd_val); // rx disabled so far; clears nothing

    // Held DATA read: one side effect only; a strobe during the hold is kept.
    io_wr(A_CTRL, 8'h03);
    rx_pulse(8'h5C);
    @(negedge clk);
    io_addr = A_DATA; io_read = 1'b1;
    #1 check("rx_read0", io_rdata, 8'h5C);
    @(negedge clk);
    rx_data = 8'h77; rx_strobe = 1'b1;
    #1 check("rx_read1", io_rdata, 8'h5C);
    @(negedge clk);
    rx_strobe = 1'b0;
    #1 check("rx_read2", io_rdata, 8'h77);
    @(negedge clk); io_read = 1'b0;
    io_rd(A_STAT, rd_val); check("status_rx_kept", rd_val, 8'h06);
    io_rd(A_DATA, rd_val); check("rx_second", rd_val, 8'h77);
    io_rd(A_STAT, rd_val); check("status_rx_clr", rd_val, 8'h02);

    // Overrun on two unread strobes; strobe on a read edge is not an overrun.
    rx_pulse(8'h11);
    rx_pulse(8'h22);
    io_rd(A_STAT, rd_val); check("status_overrun", rd_val, 8'h16);
    io_rd(A_DATA, rd_val); check("rx_overwrite", rd_val, 8'h22);
    io_wr(A_STAT, 8'h10);
    io_rd(A_STAT, rd_val); check("status_ovr_clr", rd_val, 8'h02);
    rx_pulse(8'h33);
    @(negedge clk);
    io_addr = A_DATA; io_read = 1'b1; rx_data = 8'h44; rx_strobe = 1'b1;
    #1 check("rx_edge_old", io_rdata, 8'h33);
    @(negedge clk); io_read = 1'b0; rx_strobe = 1'b0;
    io_rd(A_STAT, rd_val); check("status_no_ovr", rd_val, 8'h06);
    io_rd(A_DATA, rd_val); check("rx_edge_new", rd_val, 8'h44);

    // Flush with tx_en kept in the same write.
    io_wr(A_CTRL, 8'h01);
    io_wr(A_DATA, 8'h31);
    io_wr(A_DATA, 8'h32);
    io_wr(A_DATA, 8'h33);
    check("valid_before_flush", tx_valid, 1'b1);
    io_wr(A_CTRL, 8'h81);
    check("valid_after_flush", tx_valid, 1'b0);
    io_rd(A_STAT, rd_val); check("status_flush", rd_val, 8'h02);
    io_rd(A_CTRL, rd_val); check("ctrl_flush", rd_val, 8'h01);
    io_rd(6'h3F, rd_val); check("unmapped_read", rd_val, 8'h00);

    // Asynchronous reset between edges while a byte is pending and a read is held.
    io_wr(A_DATA, 8'h55);
    @(negedge clk);
    io_addr = A_CTRL; io_read = 1'b1;
    #1 check("pre_reset_rdata", io_rdata, 8'h01);
    #1 rst_n = 1'b0;
    #1;
    check("async_valid", tx_valid, 1'b0);
    check("async_rdata", io_rdata, 8'h00);
    check("async_txdata", tx_data, 8'h00);
    exp_q.delete();
    @(negedge clk); io_read = 1'b0; rst_n = 1'b1;
    io_rd(A_STAT, rd_val); check("post_reset_status", rd_val, 8'h02);
    io_rd(A_CTRL, rd_val); check("post_reset_ctrl", rd_val, 8'h00);
    io_wr(A_CTRL, 8'h01);
    io_wr(A_DATA, 8'h99);
    drain("drain_post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/io_port_responder.md
# io_port_responder

Peripheral-side responder for the CPU's IO interface. It decodes the IO read/write strobes driven by the pipeline control unit (IN/OUT and ALU-aux IO writes) and serves three IO-space registers: control, status and data. Bytes written to the data register are queued in a TX FIFO and drained through a valid/ready stream. Bytes arriving on an RX strobe input are held for the CPU to read back.

## Interface
- ADDR_WIDTH, 6, IO address width (64-location IO space)
- DATA_WIDTH, 8, register and stream width
- FIFO_DEPTH, 4, TX FIFO entries (power of two)
- CTRL_ADDR, 6'h0A, control register address
- STATUS_ADDR, 6'h0B, status register address
- DATA_ADDR, 6'h0C, data register address
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- io_addr  in  ADDR_WIDTH  IO address from CPU
- io_wdata  in  DATA_WIDTH  write data from CPU
- io_write  in  1  CONTROL_IO_WRITE level
- io_read  in  1  CONTROL_IO_READ level; may stay high for several cycles
- io_rdata  out  DATA_WIDTH  read data to CPU
- tx_data  out  DATA_WIDTH  FIFO head byte
- tx_valid  out  1  head byte available
- tx_ready  in  1  consumer accepts head byte
- rx_data  in  DATA_WIDTH  incoming byte
- rx_strobe  in  1  single-cycle pulse, rx_data valid

## Operation
- Strobe edge detection:
  - Registered copies of io_read and io_write are kept.
  - A write access occurs only in a cycle where io_write=1 and its copy is 0.
  - A read side effect occurs only in a cycle where io_read=1 and its copy is 0.
  - A held level therefore produces exactly one access.
- CTRL register (reset 8'h00):
  - bit0 tx_en, bit1 rx_en, bits[6:2] stored and readable.
  - bit7 flush is write-only and self-clearing; it always reads 0.
- STATUS register (read-only except W1C):
  - bit0 tx_full, bit1 tx_empty, bit2 rx_full, bit3 tx_overflow (sticky), bit4 rx_overrun (sticky), bits[7:5]=0.
  - Writing 1 to bit3 or bit4 clears that bit; all other write bits are ignored.
- DATA write: pushes io_wdata into the TX FIFO if not full. If full, the byte is dropped and tx_overflow is set.
- DATA read: returns the RX holding byte. On the read edge, rx_full is cleared.
- TX stream:
  - tx_valid = tx_en and not empty; tx_data = head entry.
  - Pop when tx_valid and tx_ready.
  - With tx_en=0 the FIFO still accepts pushes.
- RX path: when rx_strobe and rx_en, rx_data is loaded into the holding register and rx_full is set. If rx_full was already 1 and no pop occurs in the same cycle, the byte overwrites the holding register and rx_overrun is set.
- io_rdata:
  - Combinational from current register state while io_read=1: CTRL, STATUS or RX holding byte.
  - 0 for an unmapped address or when io_read=0.
- Unmapped addresses: writes ignored, no state change.

## Timing
- Reset (rst_n low, asynchronous): all of the following clear immediately, independent of clk:
  - FIFO pointers, count and storage
  - CTRL, rx_full, holding register, sticky bits, strobe copies
  - Outputs: io_rdata=0, tx_valid=0, tx_data=0.
- Write-to-stream latency: a DATA write edge at rising edge N gives tx_valid=1 (if tx_en) from cycle N+1.
- Empty FIFO plus push in the same cycle: no pop, because tx_valid was 0.
- Full FIFO plus push and pop in the same cycle: the pop completes, the push is dropped and tx_overflow is set. Fullness is evaluated before the edge.
- Flush write: count and pointers clear at that edge, and a concurrent pop is discarded. Bits[1:0] of the same write take effect at that edge.
- Pointer wrap-around: modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
- RX pop and rx_strobe in the same cycle: the new byte is loaded, rx_full stays 1 and no overrun is flagged.
- Sticky set and W1C clear in the same cycle: set wins.
- Deasserting rst_n mid-stream discards all queued bytes; the first clk edge after release behaves as a fresh start.

## Test plan
- Reset, then CTRL=8'h01, then DATA writes 8'hA1, 8'hB2 with tx_ready=1 -> tx_data shows A1 then B2 on consecutive cycles; STATUS then reads 8'h02.
- tx_en=0, write 5 bytes 8'h01..8'h05 -> STATUS=8'h09 (full, overflow); enable with tx_ready=1 -> stream 01,02,03,04, never 05. Then write STATUS=8'h08 -> STATUS=8'h02.
- Hold io_read high 3 cycles on DATA_ADDR after rx_strobe with 8'h5C -> io_rdata=8'h5C; rx_full cleared once; a subsequent rx_strobe is not lost.
- rx_en=1, two rx_strobes (8'h11, 8'h22) with no read -> DATA reads 8'h22 and STATUS bit4=1. A strobe on the same cycle as a read edge -> no overrun.
- Queue 3 bytes, write CTRL=8'h81 -> tx_valid=0 next cycle, STATUS=8'h02, CTRL reads 8'h01.
- Assert rst_n low mid-transfer between edges -> tx_valid and io_rdata go 0 immediately, before the next clk edge.
